out_port_ctrl: RTL and testbench
================================

OUT_PORT_CTRL -- requirements
Module: out_port_ctrl

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 25, the width of one CPU output word.
REQ-002 The block SHALL have parameter DEPTH, default 8, the FIFO entries (power of two, >=2).
REQ-003 The block SHALL have parameter COUNTWIDTH, default 16, the width of the word counter and limit.
REQ-004 The block SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port enable  input  1  starts a capture session when high; an abort request when dropped.
REQ-007 The block SHALL have port limit  input  COUNTWIDTH  words to capture per session; 0 = unlimited.
REQ-008 The block SHALL have port outFlag  input  1  CPU output-word strobe.
REQ-009 The block SHALL have port out  input  DATAWIDTH  CPU output word, valid when outFlag=1.
REQ-010 The block SHALL have port stall  output  1  backpressure to the CPU; high when the FIFO is full.
REQ-011 The block SHALL have port hostValid  output  1  head word available to the host.
REQ-012 The block SHALL have port hostData  output  DATAWIDTH  FIFO head word.
REQ-013 The block SHALL have port hostReady  input  1  host accepts hostData.
REQ-014 The block SHALL have port count  output  COUNTWIDTH  words accepted this session.
REQ-015 The block SHALL have port overflow  output  1  sticky: a word was dropped.
REQ-016 The block SHALL have port done  output  1  session complete and FIFO drained.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: outFlag ignored; enable=1 -> RUN next cycle, with count and overflow cleared on that transition.
REQ-019 RUN: outFlag=1 with occupancy<DEPTH at cycle start SHALL push out and increment count.
REQ-020 RUN: outFlag=1 with occupancy=DEPTH SHALL drop the word, leave count unchanged and set overflow, even if a pop occurs in the same cycle.
REQ-021 RUN -> DRAIN on the cycle a push makes count equal limit (limit!=0), or when enable=0.
REQ-022 DRAIN: outFlag ignored (no push, no count, no overflow); -> DONE when occupancy=0.
REQ-023 DONE: done=1; enable=0 -> IDLE; otherwise hold.
REQ-024 stall SHALL equal (occupancy=DEPTH), combinational from registered occupancy, in every state.
REQ-025 hostValid SHALL equal (occupancy!=0); hostData = head entry; pop when hostValid&&hostReady, in any state.
REQ-026 A word pushed in cycle N SHALL appear on hostData with hostValid=1 in cycle N+1 if the FIFO was empty.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-029 count SHALL saturate at all-ones and never wrap.
REQ-030 Words SHALL leave in exactly the order accepted; no duplication.

Reset
REQ-031 reset SHALL force state IDLE, pointers and occupancy 0, count 0, overflow 0, done 0, hostValid 0, stall 0.
REQ-032 reset mid-session SHALL discard all FIFO contents; hostData is don't-care while hostValid=0.
REQ-033 reset SHALL dominate enable, outFlag and hostReady in the same cycle.

Structure
REQ-034 A shared package out_pkg SHALL hold the FSM state enum and default DATAWIDTH/DEPTH/COUNTWIDTH constants.
REQ-035 FIFO storage and pointers SHALL be one sub-module sync_fifo (push, pop, full, empty, occupancy); the FSM and counters stay in out_port_ctrl.

Verification
REQ-036 limit=3, enable=1, hostReady=1, outFlag with 0x1,0x2,0x3,0x4 on consecutive cycles -> host receives 0x1,0x2,0x3 only; count=3; done=1; overflow=0.
REQ-037 DEPTH=8, hostReady=0, 10 outFlag words -> stall=1 after 8th push; words 9,10 dropped; overflow=1; count=8.
REQ-038 Full FIFO, hostReady=1 and outFlag=1 same cycle -> word dropped, occupancy 8->7, overflow=1.
REQ-039 limit=0, 20 words with hostReady toggling every cycle -> all 20 delivered in order; count=20; done=0 until enable drops and FIFO empties.
REQ-040 reset asserted with 5 words queued in RUN -> next cycle hostValid=0, count=0, state IDLE; later session starts clean.
REQ-041 enable dropped in RUN with 4 words queued -> outFlag ignored; 4 words drain; done=1 on the cycle after occupancy reaches 0.

Source files
------------

// File: rtl/out_pkg.sv
// Shared types and default sizes for the CPU output-port capture controller.
package out_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   localparam int DEF_DATAWIDTH  = 25;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_COUNTWIDTH = 16;

endpackage

// File: rtl/out_port_ctrl_sync_fifo.sv
// Synchronous FIFO with registered occupancy; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo
   import out_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   localparam int PTRW     = $clog2(DEPTH),
   localparam int OCCW     = PTRW + 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATAWIDTH-1:0] wr_data,
   output logic [DATAWIDTH-1:0] rd_data,
   output logic                 full,
   output logic                 empty,
   output logic [OCCW-1:0]      occupancy
);

   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic [DATAWIDTH-1:0] mem_d [DEPTH];
   logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCCW-1:0]      occ_q, occ_d;
   logic                 do_push, do_pop;

   assign full      = (occ_q == OCCW'(DEPTH));
   assign empty     = (occ_q == '0);
   assign occupancy = occ_q;
   assign rd_data   = mem_q[rd_ptr_q];

   // Full is judged on the registered occupancy, so a same-cycle pop never frees room for a push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTRW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   occ_d = occ_q + OCCW'(1);
         2'b01:   occ_d = occ_q - OCCW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/out_port_ctrl.sv
// Captures CPU output words into a FIFO for the host, one session at a time,
// with an optional word limit, sticky drop flag and drain-then-done handshake.
module out_port_ctrl
   import out_pkg::*;
#(
   parameter int DATAWIDTH  = DEF_DATAWIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int COUNTWIDTH = DEF_COUNTWIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [COUNTWIDTH-1:0] limit,
   input  logic                  outFlag,
   input  logic [DATAWIDTH-1:0]  out,
   output logic                  stall,
   output logic                  hostValid,
   output logic [DATAWIDTH-1:0]  hostData,
   input  logic                  hostReady,
   output logic [COUNTWIDTH-1:0] count,
   output logic                  overflow,
   output logic                  done
);

   localparam int OCCW = $clog2(DEPTH) + 1;

   state_e                state_q, state_d;
   logic [COUNTWIDTH-1:0] count_q, count_d, count_inc;
   logic                  overflow_q, overflow_d;
   logic                  fifo_full, fifo_empty;
   logic [OCCW-1:0]       fifo_occ;
   logic                  start, push_fire, drop, pop_fire;

   assign pop_fire = hostReady && !fifo_empty;

   sync_fifo #(
      .DATAWIDTH(DATAWIDTH),
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push_fire),
      .pop      (pop_fire),
      .wr_data  (out),
      .rd_data  (hostData),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .occupancy(fifo_occ)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The limit test uses the post-push count, so the session ends on the push that reaches it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (enable) state_d = RUN;
         RUN:   if (!enable || (push_fire && (limit != '0) && (count_inc == limit))) state_d = DRAIN;
         DRAIN: if (fifo_empty) state_d = DONE;
         DONE:  if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      start     = 1'b0;
      push_fire = 1'b0;
      drop      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: start = enable;
         RUN: begin
            push_fire = outFlag && !fifo_full;
            drop      = outFlag && fifo_full;
         end
         DRAIN: done = 1'b0;
         DONE:  done = 1'b1;
         default: done = 1'b0;
      endcase
   end

   always_comb begin
      count_inc  = (count_q == '1) ? count_q : count_q + COUNTWIDTH'(1);
      count_d    = count_q;
      overflow_d = overflow_q;
      if (start) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_fire) count_d = count_inc;
         if (drop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign stall     = (fifo_occ == OCCW'(DEPTH));
   assign hostValid = !fifo_empty;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Bench for out_port_ctrl: queue-based session model checked every cycle, plus directed scenarios.
module tb_out_port_ctrl;
   import out_pkg::*;

   localparam int DW    = 25;
   localparam int DEPTH = 8;
   localparam int CW    = 16;
   localparam int CWS   = 4;

   localparam int M_IDLE    = 0;
   localparam int M_COLLECT = 1;
   localparam int M_DRAIN   = 2;
   localparam int M_FIN     = 3;

   logic          clock     = 1'b0;
   logic          reset     = 1'b1;
   logic          enable    = 1'b0;
   logic [CW-1:0] limit     = '0;
   logic          outFlag   = 1'b0;
   logic [DW-1:0] out       = '0;
   logic          hostReady = 1'b0;

   logic           stall, hostValid, overflow, done;
   logic [DW-1:0]  hostData;
   logic [CW-1:0]  count;
   logic           stall_s, hostValid_s, overflow_s, done_s;
   logic [DW-1:0]  hostData_s;
   logic [CWS-1:0] count_s;

   out_port_ctrl #(.DATAWIDTH(DW), .DEPTH(DEPTH), .COUNTWIDTH(CW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .limit(limit),
      .outFlag(outFlag), .out(out), .stall(stall), .hostValid(hostValid),
      .hostData(hostData), .hostReady(hostReady), .count(count),
      .overflow(overflow), .done(done)
   );

   // Narrow-counter copy sharing all inputs, used to observe count saturation.
   out_port_ctrl #(.DATAWIDTH(DW), .DEPTH(DEPTH), .COUNTWIDTH(CWS)) dut_small (
      .clock(clock), .reset(reset), .enable(enable), .limit(limit[CWS-1:0]),
      .outFlag(outFlag), .out(out), .stall(stall_s), .hostValid(hostValid_s),
      .hostData(hostData_s), .hostReady(hostReady), .count(count_s),
      .overflow(overflow_s), .done(done_s)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] rx[$];
   int            m_phase = M_IDLE;
   int            m_cnt   = 0;
   bit            m_over  = 1'b0;

   int            sent, cyc, empty_cyc;
   bit            seen_empty, hit, en_r, flag_r, rdy_r;
   int            rdy_bias;
   logic [CW-1:0] lim_r;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model across one rising edge using the inputs held since the last falling edge.
   task model_step();
      bit pushed;
      bit full_now;
      pushed   = 1'b0;
      full_now = (mq.size() == DEPTH);
      if (reset) begin
         mq.delete();
         m_phase = M_IDLE;
         m_cnt   = 0;
         m_over  = 1'b0;
      end else begin
         case (m_phase)
            M_IDLE: begin
               if (enable) begin
                  m_phase = M_COLLECT;
                  m_cnt   = 0;
                  m_over  = 1'b0;
               end
            end
            M_COLLECT: begin
               if (outFlag) begin
                  if (!full_now) begin
                     pushed = 1'b1;
                     m_cnt++;
                  end else begin
                     m_over = 1'b1;
                  end
               end
               if (!enable || (pushed && limit != '0 && m_cnt == int'(limit))) m_phase = M_DRAIN;
            end
            M_DRAIN: if (mq.size() == 0) m_phase = M_FIN;
            default: if (!enable) m_phase = M_IDLE;
         endcase
         if (hostReady && mq.size() != 0) void'(mq.pop_front());
         if (pushed) mq.push_back(out);
      end
   endtask

   task compare_all();
      int sz;
      int exp_cnt, exp_cnt_s;
      sz        = mq.size();
      exp_cnt   = (m_cnt > 65535) ? 65535 : m_cnt;
      exp_cnt_s = (m_cnt > 15) ? 15 : m_cnt;
      check_output("stall", 64'(stall), 64'(sz == DEPTH));
      check_output("hostValid", 64'(hostValid), 64'(sz != 0));
      if (sz != 0) check_output("hostData", 64'(hostData), 64'(mq[0]));
      check_output("count", 64'(count), 64'(exp_cnt));
      check_output("overflow", 64'(overflow), 64'(m_over));
      check_output("done", 64'(done), 64'(m_phase == M_FIN));
      check_output("small_count", 64'(count_s), 64'(exp_cnt_s));
      check_output("small_stall", 64'(stall_s), 64'(sz == DEPTH));
      check_output("small_hostValid", 64'(hostValid_s), 64'(sz != 0));
      if (sz != 0) check_output("small_hostData", 64'(hostData_s), 64'(mq[0]));
      check_output("small_overflow", 64'(overflow_s), 64'(m_over));
      check_output("small_done", 64'(done_s), 64'(m_phase == M_FIN));
   endtask

   always @(posedge clock) begin
      if (hostValid && hostReady && !reset) rx.push_back(hostData);
      model_step();
      #1 compare_all();
   end

   task set_inputs(input logic en, input logic [CW-1:0] lim, input logic flag,
                   input logic [DW-1:0] d, input logic rdy);
      enable    = en;
      limit     = lim;
      outFlag   = flag;
      out       = d;
      hostReady = rdy;
   endtask

   task apply_stimulus(input logic en, input logic [CW-1:0] lim, input logic flag,
                       input logic [DW-1:0] d, input logic rdy);
      @(negedge clock);
      set_inputs(en, lim, flag, d, rdy);
   endtask

   task automatic wait_done(input string name, input logic en, input logic toggle);
      hit = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (done) begin
            hit = 1'b1;
            break;
         end
         set_inputs(en, limit, 1'b0, '0, toggle ? ~hostReady : 1'b1);
      end
      check_output(name, 64'(hit), 64'd1);
   endtask

   task automatic check_rx(input string name, input int n, input logic [DW-1:0] base);
      check_output({name, "_len"}, 64'(rx.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < rx.size()) check_output(name, 64'(rx[i]), 64'(base + DW'(i)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: bench exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clock);
      check_output("rst_hostValid", 64'(hostValid), 64'd0);
      check_output("rst_stall", 64'(stall), 64'd0);
      check_output("rst_count", 64'(count), 64'd0);
      check_output("rst_overflow", 64'(overflow), 64'd0);
      check_output("rst_done", 64'(done), 64'd0);
      reset = 1'b0;

      // Limit of three: the fourth word arrives while draining and is ignored.
      rx.delete();
      apply_stimulus(1'b1, 16'd3, 1'b0, 25'h0, 1'b1);
      for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 16'd3, 1'b1, DW'(i), 1'b1);
      wait_done("lim3_done", 1'b1, 1'b0);
      check_output("lim3_count", 64'(count), 64'd3);
      check_output("lim3_overflow", 64'(overflow), 64'd0);
      check_rx("lim3_rx", 3, 25'h1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, 1'b1);
      check_output("lim3_idle_done", 64'(done), 64'd0);

      // Ten words with the host stalled: two are dropped.
      rx.delete();
      apply_stimulus(1'b1, 16'd0, 1'b0, 25'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 16'd0, 1'b1, 25'h100 + DW'(i), 1'b0);
         if (i == 8) begin
            check_output("fill_stall", 64'(stall), 64'd1);
            check_output("fill_count8", 64'(count), 64'd8);
            check_output("fill_no_ovf_yet", 64'(overflow), 64'd0);
         end
      end
      apply_stimulus(1'b1, 16'd0, 1'b0, 25'h0, 1'b0);
      check_output("fill_overflow", 64'(overflow), 64'd1);
      check_output("fill_count", 64'(count), 64'd8);
      check_output("fill_occ", 64'(dut.u_fifo.occ_q), 64'd8);

      // Full FIFO, pop and push in the same cycle: push is dropped, one word leaves.
      apply_stimulus(1'b1, 16'd0, 1'b1, 25'h55, 1'b1);
      apply_stimulus(1'b1, 16'd0, 1'b0, 25'h0, 1'b0);
      check_output("fullpop_occ", 64'(dut.u_fifo.occ_q), 64'd7);
      check_output("fullpop_stall", 64'(stall), 64'd0);
      check_output("fullpop_overflow", 64'(overflow), 64'd1);
      check_output("fullpop_count", 64'(count), 64'd8);
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, 1'b1);
      wait_done("fill_done", 1'b0, 1'b0);
      check_rx("fill_rx", 8, 25'h100);

      // Unlimited session, host ready toggling, CPU honouring stall.
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, 1'b0);
      rx.delete();
      apply_stimulus(1'b1, 16'd0, 1'b0, 25'h0, 1'b0);
      sent = 0;
      cyc  = 0;
      while (sent < 20 && cyc < 200) begin
         @(negedge clock);
         flag_r = !stall;
         set_inputs(1'b1, 16'd0, flag_r, 25'h200 + DW'(sent), ~hostReady);
         if (flag_r) sent++;
         cyc++;
      end
      check_output("unl_sent", 64'(sent), 64'd20);
      apply_stimulus(1'b1, 16'd0, 1'b0, 25'h0, ~hostReady);
      check_output("unl_not_done", 64'(done), 64'd0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, ~hostReady);
      wait_done("unl_done", 1'b0, 1'b1);
      check_output("unl_count", 64'(count), 64'd20);
      check_output("unl_overflow", 64'(overflow), 64'd0);
      check_rx("unl_rx", 20, 25'h200);

      // Reset in the middle of a session with five words queued.
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, 1'b0);
      rx.delete();
      apply_stimulus(1'b1, 16'd0, 1'b0, 25'h0, 1'b0);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 16'd0, 1'b1, 25'h300 + DW'(i), 1'b0);
      @(negedge clock);
      reset = 1'b1;
      set_inputs(1'b1, 16'd0, 1'b1, 25'h3ff, 1'b1);
      @(negedge clock);
      check_output("rstmid_hostValid", 64'(hostValid), 64'd0);
      check_output("rstmid_count", 64'(count), 64'd0);
      check_output("rstmid_state", 64'(dut.state_q), 64'(IDLE));
      check_output("rstmid_occ", 64'(dut.u_fifo.occ_q), 64'd0);
      check_output("rstmid_rx", 64'(rx.size()), 64'd0);
      reset = 1'b0;
      set_inputs(1'b1, 16'd2, 1'b0, 25'h0, 1'b1);
      apply_stimulus(1'b1, 16'd2, 1'b1, 25'h3a, 1'b1);
      apply_stimulus(1'b1, 16'd2, 1'b1, 25'h3b, 1'b1);
      wait_done("rstmid_done", 1'b1, 1'b0);
      check_output("rstmid_new_count", 64'(count), 64'd2);
      check_rx("rstmid_new_rx", 2, 25'h3a);

      // Enable dropped with four words queued; later words are ignored while draining.
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, 1'b0);
      rx.delete();
      apply_stimulus(1'b1, 16'd0, 1'b0, 25'h0, 1'b0);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 16'd0, 1'b1, 25'h400 + DW'(i), 1'b0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 25'h0, 1'b0);
      seen_empty = 1'b0;
      hit        = 1'b0;
      empty_cyc  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (!seen_empty && !hostValid) begin
            seen_empty = 1'b1;
            empty_cyc  = i;
            check_output("abort_done_at_empty", 64'(done), 64'd0);
         end else if (seen_empty && i == empty_cyc + 1) begin
            check_output("abort_done_after_empty", 64'(done), 64'd1);
            hit = 1'b1;
            break;
         end
         set_inputs(1'b0, 16'd0, 1'b1, 25'h7ff, 1'b1);
      end
      check_output("abort_reached_done", 64'(hit), 64'd1);
      check_output("abort_count", 64'(count), 64'd4);
      check_output("abort_overflow", 64'(overflow), 64'd0);
      check_rx("abort_rx", 4, 25'h400);

      // Randomised traffic, including resets, limit changes and session aborts.
      en_r     = 1'b0;
      lim_r    = '0;
      rdy_bias = 1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         if (c % 256 == 0) rdy_bias = $urandom_range(0, 3);
         reset = ($urandom_range(0, 999) < 4);
         if ($urandom_range(0, 29) == 0) en_r = ~en_r;
         if ($urandom_range(0, 49) == 0)
            lim_r = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 12));
         flag_r = ($urandom_range(0, 2) != 0);
         rdy_r  = ($urandom_range(0, 3) < rdy_bias);
         set_inputs(en_r, lim_r, flag_r, DW'($urandom), rdy_r);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
